// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: stores push bytes into a FIFO that the
// frame FSM drains LSB first onto UART_RXD_OUT, back-to-back when bytes are waiting.
module uart_tx_port #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               write_en,
    input  logic [7:0]                         write_data,
    output logic                               full,
    output logic                               busy,
    output logic                               overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               UART_RXD_OUT
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            line_q, line_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      fifo_mem [FIFO_DEPTH];

    logic            bit_end;
    logic            push;
    logic            pop;

    assign bit_end = (baud_q == BIT_END);
    // Acceptance uses the registered full flag, so a same-edge pop never rescues a write.
    assign push    = write_en && !full_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            line_q     <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            line_q     <= line_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= write_data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_START;
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA:  if (bit_end && bit_idx_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (bit_end) state_d = (count_q != '0) ? S_START : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop = (state_q == S_IDLE || (state_q == S_STOP && bit_end)) && (count_q != '0);

        baud_d = (state_q == S_IDLE || bit_end) ? '0 : baud_q + CW'(1);

        bit_idx_d = bit_idx_q;
        if (state_q == S_START) begin
            bit_idx_d = 3'd0;
        end else if (state_q == S_DATA && bit_end) begin
            bit_idx_d = bit_idx_q + 3'd1;
        end

        shift_d = pop ? fifo_mem[rd_ptr_q] : shift_q;

        // The line is registered from the next state so it changes on the same edge as the FSM.
        case (state_d)
            S_START: line_d = 1'b0;
            S_DATA:  line_d = shift_d[bit_idx_d];
            default: line_d = 1'b1;
        endcase

        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + NW'(push) - NW'(pop);
        full_d     = (count_d == NW'(FIFO_DEPTH));
        overflow_d = overflow_q | (write_en & full_q);
    end

    assign UART_RXD_OUT = line_q;
    assign full         = full_q;
    assign overflow     = overflow_q;
    assign fifo_count   = count_q;
    assign busy         = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: a queue-and-timeline model of the serial frames checked every
// cycle, plus directed scenarios with hand-derived waveform literals.
module tb_uart_tx_port;
    localparam int CPB   = 8;
    localparam int FRAME = 10 * CPB;
    localparam int DEPTH = 16;

    logic       CLK;
    logic       RST;
    logic       write_en;
    logic [7:0] write_data;
    logic       full, busy, overflow, UART_RXD_OUT;
    logic [4:0] fifo_count;

    logic       d_we;
    logic [7:0] d_wd;
    logic       d_full, d_busy, d_ovf, d_line;
    logic [4:0] d_count;

    int checks = 0;
    int errors = 0;

    uart_tx_port #(.CLK_FREQ(8), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .write_en(write_en), .write_data(write_data),
        .full(full), .busy(busy), .overflow(overflow), .fifo_count(fifo_count),
        .UART_RXD_OUT(UART_RXD_OUT)
    );

    uart_tx_port dut_def (
        .CLK(CLK), .RST(RST), .write_en(d_we), .write_data(d_wd),
        .full(d_full), .busy(d_busy), .overflow(d_ovf), .fifo_count(d_count),
        .UART_RXD_OUT(d_line)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event at %0t", name, $time);
    endtask

    // Model: FIFO as a queue; the frame as a position 0..FRAME-1 into the byte being sent.
    logic [7:0] m_q[$];
    bit         m_active = 0;
    int         m_pos = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_ovf = 0;
    bit         model_ok = 0;

    always @(posedge CLK) begin
        bit full_prev, do_pop;
        if (RST) begin
            m_q.delete();
            m_active = 0;
            m_pos    = 0;
            m_ovf    = 0;
            model_ok = 1;
        end else begin
            full_prev = (m_q.size() == DEPTH);
            do_pop    = (m_q.size() != 0) && (!m_active || m_pos == FRAME - 1);
            if (write_en && full_prev) m_ovf = 1;
            if (do_pop) begin
                m_byte   = m_q.pop_front();
                m_active = 1;
                m_pos    = 0;
            end else if (m_active) begin
                if (m_pos == FRAME - 1) m_active = 0;
                else m_pos++;
            end
            if (write_en && !full_prev) m_q.push_back(write_data);
        end
    end

    function automatic logic exp_line();
        int k;
        if (!m_active) return 1'b1;
        k = m_pos / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    always @(negedge CLK) begin
        if (model_ok) begin
            chk("line", {31'd0, UART_RXD_OUT}, {31'd0, exp_line()});
            chk("busy", {31'd0, busy}, {31'd0, (m_active || m_q.size() != 0)});
            chk("full", {31'd0, full}, {31'd0, (m_q.size() == DEPTH)});
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("fifo_count", {27'd0, fifo_count}, 32'(m_q.size()));
        end
    end

    task automatic do_reset();
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
    endtask

    task automatic wait_line_low();
        int n = 0;
        while (UART_RXD_OUT !== 1'b0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) timeout("line_fall");
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (n >= budget) timeout("busy_drop");
    endtask

    // Starting at the first low sample, take one mid-bit sample per bit period.
    task automatic capture(input int nframes, output logic [31:0] bits, output int busy_hi);
        bits = '0;
        busy_hi = 0;
        for (int c = 0; c < nframes * FRAME; c++) begin
            if (c % CPB == CPB / 2) bits[c / CPB] = UART_RXD_OUT;
            if (busy) busy_hi++;
            @(negedge CLK);
        end
    endtask

    task automatic write_seq(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            write_en   = 1'b1;
            write_data = base + 8'(i);
        end
        @(negedge CLK);
        write_en = 1'b0;
    endtask

    initial begin
        logic [31:0] bits;
        int busy_hi, lows, lo, hi, n;
        RST = 1'b1; write_en = 1'b0; write_data = 8'h00; d_we = 1'b0; d_wd = 8'h00;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk("reset_line", {31'd0, UART_RXD_OUT}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_count", {27'd0, fifo_count}, 32'd0);

        // 1) single 0x55 frame
        write_seq(1, 8'h55);
        wait_line_low();
        capture(1, bits, busy_hi);
        chk("t1_bits", {22'd0, bits[9:0]}, 32'h2AA);
        chk("t1_busy_cycles", 32'(busy_hi), 32'd80);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        chk("t1_overflow", {31'd0, overflow}, 32'd0);

        // 2) 0xA5 then 0x3C back to back
        do_reset();
        @(negedge CLK); write_en = 1'b1; write_data = 8'hA5;
        @(negedge CLK); write_data = 8'h3C;
        @(negedge CLK); write_en = 1'b0;
        chk("t2_count_one", {27'd0, fifo_count}, 32'd1);
        wait_line_low();
        capture(2, bits, busy_hi);
        chk("t2_bits", {12'd0, bits[19:0]}, {12'd0, 20'b1001111000_1101001010});
        chk("t2_busy_cycles", 32'(busy_hi), 32'd160);
        chk("t2_busy_end", {31'd0, busy}, 32'd0);

        // 3) 18 writes: one in flight, 16 queued, one dropped
        do_reset();
        write_seq(18, 8'h10);
        chk("t3_full", {31'd0, full}, 32'd1);
        chk("t3_count", {27'd0, fifo_count}, 32'd16);
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        wait_idle(2000);
        chk("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

        // 4) reset during data bit 3 of 0xFF with bytes queued
        do_reset();
        @(negedge CLK); write_en = 1'b1; write_data = 8'hFF;
        @(negedge CLK); write_data = 8'h01;
        @(negedge CLK); write_data = 8'h02;
        @(negedge CLK); write_data = 8'h03;
        @(negedge CLK); write_en = 1'b0;
        repeat (32) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("t4_line", {31'd0, UART_RXD_OUT}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_count", {27'd0, fifo_count}, 32'd0);
        lows = 0;
        repeat (100) begin
            @(negedge CLK);
            if (!UART_RXD_OUT) lows++;
        end
        chk("t4_no_fall", 32'(lows), 32'd0);

        // 5) write while full on the stop-end edge that pops
        do_reset();
        write_seq(17, 8'h40);
        chk("t5_full", {31'd0, full}, 32'd1);
        chk("t5_no_ovf_yet", {31'd0, overflow}, 32'd0);
        repeat (64) @(negedge CLK);
        write_en = 1'b1; write_data = 8'hEE;
        @(negedge CLK);
        write_en = 1'b0;
        chk("t5_overflow", {31'd0, overflow}, 32'd1);
        chk("t5_count", {27'd0, fifo_count}, 32'd15);
        chk("t5_not_full", {31'd0, full}, 32'd0);
        wait_idle(2000);

        // 6) default parameters: 868-cycle bits
        @(negedge CLK); d_we = 1'b1; d_wd = 8'hFF;
        @(negedge CLK); d_we = 1'b0;
        n = 0;
        while (d_line !== 1'b0 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 10) timeout("t6_fall");
        lo = 0; hi = 0; n = 0;
        while (d_busy === 1'b1 && n < 10000) begin
            if (!d_line) lo++;
            hi++;
            @(negedge CLK);
            n++;
        end
        if (n >= 10000) timeout("t6_frame");
        chk("t6_start_bit", 32'(lo), 32'd868);
        chk("t6_frame", 32'(hi), 32'd8680);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
